// File: rtl/ps2_cmd_arbiter_pkg.sv
// Shared types and byte codes for the PS/2 command arbiter.
// Holds the FSM state encoding, device response codes and host command codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RSP,
    FINISH,
    FAIL
  } state_t;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_BAT_OK = 8'hAA;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_ENABLE    = 8'hF4;
  localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_cmd_arbiter_if.sv
// Requester and PS/2 host-engine signals of the command arbiter.
// slave is the arbiter side, master is the requester/host-engine side.
interface ps2_cmd_arbiter_if;

  logic [1:0]  req;
  logic [15:0] req_cmd;
  logic [15:0] req_arg;
  logic [1:0]  req_has_arg;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        busy;

  logic        ps2_wr_stb;
  logic [7:0]  ps2_wr_data;
  logic        ps2_tx_done;
  logic        ps2_rddata_valid;
  logic [7:0]  ps2_rd_data;

  logic        scan_valid;
  logic [7:0]  scan_data;

  modport slave (
    input  req, req_cmd, req_arg, req_has_arg,
    input  ps2_tx_done, ps2_rddata_valid, ps2_rd_data,
    output gnt, done, err, busy,
    output ps2_wr_stb, ps2_wr_data,
    output scan_valid, scan_data
  );

  modport master (
    output req, req_cmd, req_arg, req_has_arg,
    output ps2_tx_done, ps2_rddata_valid, ps2_rd_data,
    input  gnt, done, err, busy,
    input  ps2_wr_stb, ps2_wr_data,
    input  scan_valid, scan_data
  );

endinterface

// File: rtl/ps2_cmd_arbiter_rsp_timer.sv
// Loadable saturating response timer; expired flags the last cycle of the window.
module ps2_rsp_timer
  import ps2_pkg::*;
#(
  parameter int unsigned LIMIT = 2000000,
  localparam int unsigned W = cnt_width(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Holds at all-ones so a long wait can never wrap back into range.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_LAST);

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Shares the PS/2 host transmit channel between two command requesters.
// Define PS2_ARB_ROUND_ROBIN_EN for alternating arbitration; default is fixed priority.
module ps2_cmd_arbiter
  import ps2_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 2000000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [7:0]  BYTE_ACK    = ps2_pkg::BYTE_ACK,
  parameter logic [7:0]  BYTE_RESEND = ps2_pkg::BYTE_RESEND
) (
  input logic          clk,
  input logic          rst,
  ps2_cmd_arbiter_if.slave bus
);

  localparam int unsigned TW = cnt_width(ACK_TIMEOUT);
  localparam int unsigned RW = cnt_width(MAX_RETRY + 1);

  state_t          state;
  logic            owner;
  logic [7:0]      cur_cmd;
  logic [7:0]      cur_arg;
  logic            cur_has_arg;
  logic            on_arg;
  logic [RW-1:0]   retries;
  logic            winner;
  logic            rsp_ack;
  logic            rsp_resend;
  logic            consume;
  logic            timer_clear;
  logic            timer_en;
  logic            timer_expired;
  logic [7:0]      cur_byte;

`ifdef PS2_ARB_ROUND_ROBIN_EN
  logic            ptr;

  always_comb begin
    winner = bus.req[ptr] ? ptr : ~ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if ((state == IDLE) && (|bus.req)) begin
      ptr <= ~winner;
    end
  end
`else
  always_comb begin
    winner = ~bus.req[0];
  end
`endif

  assign rsp_ack     = (state == WAIT_RSP) && bus.ps2_rddata_valid && (bus.ps2_rd_data == BYTE_ACK);
  assign rsp_resend  = (state == WAIT_RSP) && bus.ps2_rddata_valid && (bus.ps2_rd_data == BYTE_RESEND);
  assign consume     = rsp_ack || rsp_resend;
  assign timer_clear = (state == WAIT_TX) && bus.ps2_tx_done;
  assign timer_en    = (state == WAIT_RSP);
  assign cur_byte    = on_arg ? cur_arg : cur_cmd;

  ps2_rsp_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .load     (1'b0),
    .load_val ('0),
    .en       (timer_en),
    .expired  (timer_expired)
  );

  // The strobe is raised on the edge that enters SEND, so it is high exactly for the SEND cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      cur_cmd         <= '0;
      cur_arg         <= '0;
      cur_has_arg     <= 1'b0;
      on_arg          <= 1'b0;
      retries         <= '0;
      bus.gnt         <= '0;
      bus.done        <= '0;
      bus.err         <= '0;
      bus.busy        <= 1'b0;
      bus.ps2_wr_stb  <= 1'b0;
      bus.ps2_wr_data <= '0;
    end else begin
      bus.gnt        <= '0;
      bus.done       <= '0;
      bus.err        <= '0;
      bus.ps2_wr_stb <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            owner           <= winner;
            cur_cmd         <= winner ? bus.req_cmd[15:8] : bus.req_cmd[7:0];
            cur_arg         <= winner ? bus.req_arg[15:8] : bus.req_arg[7:0];
            cur_has_arg     <= bus.req_has_arg[winner];
            on_arg          <= 1'b0;
            retries         <= '0;
            bus.gnt         <= 2'b01 << winner;
            bus.busy        <= 1'b1;
            bus.ps2_wr_stb  <= 1'b1;
            bus.ps2_wr_data <= winner ? bus.req_cmd[15:8] : bus.req_cmd[7:0];
            state           <= SEND;
          end
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.ps2_tx_done) begin
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // An ACK wins over a timeout expiring in the same cycle.
          if (rsp_ack) begin
            if (!on_arg && cur_has_arg) begin
              on_arg          <= 1'b1;
              retries         <= '0;
              bus.ps2_wr_stb  <= 1'b1;
              bus.ps2_wr_data <= cur_arg;
              state           <= SEND;
            end else begin
              bus.done <= 2'b01 << owner;
              state    <= FINISH;
            end
          end else if (rsp_resend || timer_expired) begin
            if (retries < RW'(MAX_RETRY)) begin
              retries         <= retries + 1'b1;
              bus.ps2_wr_stb  <= 1'b1;
              bus.ps2_wr_data <= cur_byte;
              state           <= SEND;
            end else begin
              bus.err <= 2'b01 << owner;
              state   <= FAIL;
            end
          end
        end
        FINISH, FAIL: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Everything except ACK/RESEND taken as a protocol response reaches the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.scan_valid <= 1'b0;
      bus.scan_data  <= '0;
    end else begin
      bus.scan_valid <= bus.ps2_rddata_valid && !consume;
      if (bus.ps2_rddata_valid && !consume) begin
        bus.scan_data <= bus.ps2_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Randomized bench for ps2_cmd_arbiter with a transaction-level reference model.
// Honours PS2_ARB_ROUND_ROBIN_EN when predicting the grant order.
`timescale 1ns/1ps
module tb_ps2_cmd_arbiter;
  import ps2_pkg::*;

  localparam int AT    = 150;
  localparam int MR    = 3;
  localparam int K_ACK = 0;
  localparam int K_RESEND = 1;
  localparam int K_NONE = 2;
  localparam int LIMIT = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_cmd_arbiter_if bus();

  ps2_cmd_arbiter #(
    .ACK_TIMEOUT(AT),
    .MAX_RETRY  (MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] cmd_v[2];
  logic [7:0] arg_v[2];
  logic       has_v[2];
  logic [7:0] cmds[4] = '{CMD_RESET, CMD_ENABLE, CMD_SET_LEDS, CMD_TYPEMATIC};
  bit         hold_req = 0;
  bit         pref = 0;

  logic [7:0] obs_stb[$];
  int         obs_stb_cyc[$];
  int         txd_cyc[$];
  logic [1:0] gnt_acc, done_acc, err_acc;
  int         gnt_cnt, done_cnt, err_cnt, err_cyc;
  logic [7:0] exp_scan[$];

  int         rsp_script[$];
  int         rsp_delay_fixed = 0;
  bit         noise_rsp = 0;
  bit         noise_txd = 0;
  logic [7:0] noise_fixed = 8'h00;

  logic [7:0] exp_bytes[$];
  int         exp_kinds[$];
  bit         exp_ok;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic apply_stimulus();
    bus.req_cmd     = {cmd_v[1], cmd_v[0]};
    bus.req_arg     = {arg_v[1], arg_v[0]};
    bus.req_has_arg = {has_v[1], has_v[0]};
  endtask

  // One clock: sample outputs 1 ns after the edge and log every event.
  task automatic tick();
    logic [8:0] e;
    @(posedge clk);
    #1;
    cyc++;
    check_output("excl", 32'($countones({bus.gnt, bus.done, bus.err}) <= 1), 1);
    if (bus.gnt != 2'b00) begin
      gnt_acc |= bus.gnt;
      gnt_cnt++;
      if (!hold_req) bus.req &= ~bus.gnt;
    end
    if (bus.done != 2'b00) begin
      done_acc |= bus.done;
      done_cnt++;
    end
    if (bus.err != 2'b00) begin
      err_acc |= bus.err;
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.ps2_wr_stb) begin
      obs_stb.push_back(bus.ps2_wr_data);
      obs_stb_cyc.push_back(cyc);
    end
    if (bus.scan_valid) begin
      e = (exp_scan.size() != 0) ? {1'b0, exp_scan.pop_front()} : 9'h1FF;
      check_output("scan", {23'd0, 1'b0, bus.scan_data}, {23'd0, e});
    end
  endtask

  function automatic logic [7:0] pick_noise();
    if (noise_fixed != 8'h00) return noise_fixed;
    return 8'($urandom_range(1, 239));
  endfunction

  // Host engine plus device: shift the byte out, then answer (or stay silent).
  task automatic respond(input int kind);
    int d;
    logic [7:0] n;
    repeat ($urandom_range(2, 8)) tick();
    bus.ps2_tx_done = 1'b1;
    if (noise_txd) begin
      n = pick_noise();
      bus.ps2_rddata_valid = 1'b1;
      bus.ps2_rd_data = n;
      exp_scan.push_back(n);
    end
    tick();
    txd_cyc.push_back(cyc);
    bus.ps2_tx_done = 1'b0;
    bus.ps2_rddata_valid = 1'b0;
    if (kind == K_NONE) return;
    d = (rsp_delay_fixed != 0) ? rsp_delay_fixed : $urandom_range(1, 60);
    for (int i = 1; i < d; i++) begin
      if (noise_rsp && (i == d / 2)) begin
        n = pick_noise();
        bus.ps2_rddata_valid = 1'b1;
        bus.ps2_rd_data = n;
        exp_scan.push_back(n);
      end
      tick();
      bus.ps2_rddata_valid = 1'b0;
    end
    bus.ps2_rddata_valid = 1'b1;
    bus.ps2_rd_data = (kind == K_ACK) ? BYTE_ACK : BYTE_RESEND;
    tick();
    bus.ps2_rddata_valid = 1'b0;
  endtask

  function automatic int script_kind(input int j);
    return (j < rsp_script.size()) ? rsp_script[j] : K_ACK;
  endfunction

  function automatic int model_winner(input logic [1:0] r);
`ifdef PS2_ARB_ROUND_ROBIN_EN
    if (r[pref]) return int'(pref);
    return int'(!pref);
`else
    return r[0] ? 0 : 1;
`endif
  endfunction

  // Each byte gets one send plus up to MR resends; any miss beyond that fails the request.
  function automatic void model_txn(input logic [7:0] c, input logic [7:0] a, input logic ha);
    int k, tries, r;
    exp_bytes.delete();
    exp_kinds.delete();
    exp_ok = 1;
    k = 0;
    for (int b = 0; b < (ha ? 2 : 1) && exp_ok; b++) begin
      tries = 0;
      while (1) begin
        r = script_kind(k);
        k++;
        exp_bytes.push_back(b == 1 ? a : c);
        exp_kinds.push_back(r);
        if (r == K_ACK) break;
        if (tries == MR) begin
          exp_ok = 0;
          break;
        end
        tries++;
      end
    end
  endfunction

  task automatic run_txn(input logic [1:0] new_req, input string name);
    int base, w, lim, handled, nobs;
    bit fin;
    base = obs_stb.size();
    txd_cyc.delete();
    gnt_acc = 0; done_acc = 0; err_acc = 0;
    gnt_cnt = 0; done_cnt = 0; err_cnt = 0;
    bus.req |= new_req;
    apply_stimulus();
    w = model_winner(bus.req);
`ifdef PS2_ARB_ROUND_ROBIN_EN
    pref = (w == 0);
`endif
    model_txn(cmd_v[w], arg_v[w], has_v[w]);
    handled = 0;
    fin = 0;
    lim = 0;
    while (!fin && lim < LIMIT) begin
      if ((done_acc | err_acc) != 2'b00) fin = 1;
      else if (obs_stb.size() - base > handled) begin
        respond(script_kind(handled));
        handled++;
      end else begin
        tick();
        lim++;
      end
    end
    check_output({name, "_complete"}, 32'(fin), 1);
    check_output({name, "_gnt"}, 32'(gnt_acc), 32'(2'b01 << w));
    check_output({name, "_gnt_cnt"}, gnt_cnt, 1);
    nobs = obs_stb.size() - base;
    check_output({name, "_strobes"}, nobs, exp_bytes.size());
    for (int j = 0; j < exp_bytes.size() && j < nobs; j++)
      check_output({name, "_byte"}, 32'(obs_stb[base + j]), 32'(exp_bytes[j]));
    check_output({name, "_done"}, 32'(done_acc), exp_ok ? 32'(2'b01 << w) : 0);
    check_output({name, "_err"}, 32'(err_acc), exp_ok ? 0 : 32'(2'b01 << w));
    check_output({name, "_pulses"}, done_cnt + err_cnt, 1);
    for (int j = 0; j < exp_kinds.size(); j++) begin
      if (exp_kinds[j] == K_NONE && j < txd_cyc.size()) begin
        if (j + 1 < exp_bytes.size()) begin
          if (base + j + 1 < obs_stb.size())
            check_output({name, "_retry_gap"}, obs_stb_cyc[base + j + 1] - txd_cyc[j], AT);
        end else if (!exp_ok) begin
          check_output({name, "_err_gap"}, err_cyc - txd_cyc[j], AT);
        end
      end
    end
    check_output({name, "_busy_end"}, 32'(bus.busy), 1);
    tick();
    check_output({name, "_busy_idle"}, 32'(bus.busy), 0);
    check_output({name, "_scan_left"}, exp_scan.size(), 0);
    exp_scan.delete();
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_gnt"}, 32'(bus.gnt), 0);
    check_output({name, "_done"}, 32'(bus.done), 0);
    check_output({name, "_err"}, 32'(bus.err), 0);
    check_output({name, "_busy"}, 32'(bus.busy), 0);
    check_output({name, "_stb"}, 32'(bus.ps2_wr_stb), 0);
    check_output({name, "_wdata"}, 32'(bus.ps2_wr_data), 0);
    check_output({name, "_scan_v"}, 32'(bus.scan_valid), 0);
    check_output({name, "_scan_d"}, 32'(bus.scan_data), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx, n, r;
    bit found;
    bus.req = 2'b00;
    bus.ps2_tx_done = 1'b0;
    bus.ps2_rddata_valid = 1'b0;
    bus.ps2_rd_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      cmd_v[i] = 8'h00; arg_v[i] = 8'h00; has_v[i] = 1'b0;
    end
    apply_stimulus();
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Enable command answered 100 cycles after tx_done.
    cmd_v[0] = CMD_ENABLE; has_v[0] = 1'b0;
    rsp_script = '{K_ACK};
    rsp_delay_fixed = 100;
    run_txn(2'b01, "enable");
    rsp_delay_fixed = 0;

    cmd_v[1] = CMD_SET_LEDS; arg_v[1] = 8'h07; has_v[1] = 1'b1;
    rsp_script = '{K_ACK, K_ACK};
    run_txn(2'b10, "leds");

    cmd_v[0] = CMD_RESET; has_v[0] = 1'b0;
    rsp_script = '{K_RESEND, K_RESEND, K_ACK};
    run_txn(2'b01, "resend2");

    rsp_script = '{K_RESEND, K_RESEND, K_RESEND, K_RESEND};
    run_txn(2'b01, "resend4");

    rsp_script = '{K_NONE, K_NONE, K_NONE, K_NONE};
    run_txn(2'b01, "silent");

    cmd_v[1] = CMD_TYPEMATIC; arg_v[1] = 8'h20; has_v[1] = 1'b1;
    rsp_script = '{K_NONE, K_ACK, K_RESEND, K_ACK};
    run_txn(2'b10, "mixed");

    // A make code arriving while the ACK is still outstanding.
    cmd_v[0] = CMD_ENABLE;
    rsp_script = '{K_ACK};
    noise_rsp = 1; noise_fixed = 8'h1D; rsp_delay_fixed = 40;
    run_txn(2'b01, "scan1d");
    noise_rsp = 0; noise_fixed = 8'h00; rsp_delay_fixed = 0;

    // Stray ACK code while idle must be forwarded one cycle later.
    exp_scan.push_back(BYTE_ACK);
    bus.ps2_rddata_valid = 1'b1;
    bus.ps2_rd_data = BYTE_ACK;
    tick();
    bus.ps2_rddata_valid = 1'b0;
    check_output("stray_fa_seen", exp_scan.size(), 0);
    tick();
    check_output("stray_fa_once", 32'(bus.scan_valid), 0);
    exp_scan.delete();

    // Both requesters held continuously.
    hold_req = 1;
    cmd_v[0] = CMD_ENABLE; has_v[0] = 1'b0;
    cmd_v[1] = CMD_SET_LEDS; arg_v[1] = 8'h02; has_v[1] = 1'b1;
    rsp_script.delete();
    run_txn(2'b11, "held_a");
    run_txn(2'b00, "held_b");
    run_txn(2'b00, "held_c");
    bus.req = 2'b00;
    hold_req = 0;

    // Loser stays pending and is served next.
    run_txn(2'b11, "pend_a");
    run_txn(2'b00, "pend_b");

    // Reset while the byte is being shifted out.
    gnt_acc = 0; done_acc = 0; err_acc = 0;
    cmd_v[0] = CMD_RESET; has_v[0] = 1'b0;
    apply_stimulus();
    bus.req[0] = 1'b1;
    n = obs_stb.size();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (obs_stb.size() > n) found = 1;
    end
    check_output("rst_mid_stb", 32'(found), 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;
    pref = 0;
    bus.req = 2'b00;
    repeat (5) tick();
    check_output("rst_mid_no_pulse", 32'(done_acc | err_acc), 0);
    check_output("rst_mid_busy", 32'(bus.busy), 0);

    for (int t = 0; t < 16; t++) begin
      idx = $urandom_range(0, 1);
      cmd_v[idx] = cmds[$urandom_range(0, 3)];
      arg_v[idx] = 8'($urandom);
      has_v[idx] = 1'($urandom_range(0, 1));
      rsp_script.delete();
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 9);
        rsp_script.push_back(r < 5 ? K_ACK : (r < 8 ? K_RESEND : K_NONE));
      end
      noise_rsp = 1'($urandom_range(0, 1));
      noise_txd = ($urandom_range(0, 3) == 0);
      run_txn(2'b01 << idx, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
